// File: rtl/mem_port_arbiter.sv
// Purpose : shares the single-port 64-bit data memory between instruction fetch and load/store.
// Latency : store done 2 cycles after the request is seen in IDLE; read done 2+MEM_LAT cycles after.
// Backpressure: requests are levels held until their done pulse; a losing request waits in IDLE.
//
// Ports:
//   clock, reset (synchronous, active-low)
//   i_req/i_addr -> i_done/i_rdata            fetch port (32-bit word select by address bit 2)
//   d_req/d_we/d_addr/d_wdata -> d_done/d_rdata   load/store port (64-bit)
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata  memory side, all outputs registered
//   busy                                       high whenever the sequencer is not in IDLE
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests;
// otherwise data has fixed priority over fetch.

module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic       owner_d;   // 1 = transaction belongs to the data port
  logic       cap_we;    // captured store flag (only ever set for data grants)
  logic [3:0] lat_cnt;
  logic       grant_d;   // data port wins the arbitration this cycle

`ifdef MEM_ARB_RR_EN
  logic rr_data;         // 1 = data wins a tie; flips to the other port on every grant

  always_comb begin
    grant_d = d_req & (~i_req | rr_data);
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // mem_addr and mem_wdata double as the captured address/write-data registers,
  // so they stay frozen from grant until the next grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      cap_we    <= 1'b0;
      lat_cnt   <= 4'd0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 64'd0;
      i_rdata   <= 32'd0;
      d_rdata   <= 64'd0;
`ifdef MEM_ARB_RR_EN
      rr_data   <= 1'b1;
`endif
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state    <= ISSUE;
            owner_d  <= grant_d;
            cap_we   <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : i_addr;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
            mem_en   <= 1'b1;
            mem_wr   <= grant_d & d_we;
            busy     <= 1'b1;
`ifdef MEM_ARB_RR_EN
            rr_data  <= ~grant_d;
`endif
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (cap_we) begin
            state  <= DONE;
            d_done <= 1'b1;
          end else begin
            state   <= WAIT;
            lat_cnt <= 4'(MEM_LAT);
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            // Last wait cycle: memory data is valid now, hand it to the owner.
            state   <= DONE;
            lat_cnt <= 4'd0;
            if (owner_d) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
              i_done  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
